// File: rtl/uart_mon_pkg.sv
// Shared types for the UART debug receiver: receive FSM states and frame width.
package uart_mon_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO. The head word comes straight from the storage array
// via the registered read pointer. A push into a full FIFO is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full, pop, wr_en;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign valid   = (count_reg != '0);
    assign pop     = valid && ready;
    assign wr_en   = push && (!full || pop);
    assign dropped = push && full && !pop;
    assign count   = count_reg;
    assign head    = valid ? mem[rd_ptr_reg] : '0;

    always_comb begin
        count_next = count_reg;
        if (wr_en && !pop)
            count_next = count_reg + CNT_W'(1);
        else if (pop && !wr_en)
            count_next = count_reg - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= push_data;
    end

    // Pointer widths match DEPTH (a power of two), so they wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 receiver for the MCU uart_tx debug line. Bytes are buffered in a FWFT FIFO.
// Framing errors and dropped bytes are reported on dedicated outputs.
module uart_rx_monitor
    import uart_mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic [1:0]           sync_reg;
    logic                 rx_s;
    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overflow_reg;
    logic                 push, dropped;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Synchroniser flops reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync_reg <= 2'b11;
        else
            sync_reg <= {sync_reg[0], rx};
    end
    assign rx_s = sync_reg[1];

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        shift_next     = shift_reg;
        push           = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_reg == '0) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_next   = CNT_FULL;
                        idx_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                    cnt_next   = CNT_FULL;
                    if (idx_reg == IDX_LAST)
                        state_next = STOP;
                    else
                        idx_next = idx_reg + IDX_W'(1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start.
                if (cnt_reg == '0) begin
                    if (rx_s) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Sticky drop flag; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow_reg <= 1'b0;
        else if (dropped)
            overflow_reg <= 1'b1;
        else if (overflow_clr)
            overflow_reg <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .head      (out_data),
        .valid     (out_valid),
        .ready     (out_ready),
        .count     (fifo_count),
        .dropped   (dropped)
    );

    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: latency, buffering, overflow, framing error,
// glitch rejection and mid-frame reset, each against hand-computed values.
module tb_uart_rx_monitor;
    import uart_mon_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       frame_err;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    int         checks = 0;
    int         failures = 0;
    int         fe_cnt = 0;
    int         lat;
    int         fe_base;
    logic [7:0] popped[$];

    uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            popped.push_back(out_data);
        if (frame_err)
            fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [7:0] pq(input int i);
        if (i < popped.size())
            return popped[i];
        return 8'hxx;
    endfunction

    // Drives one frame starting at the next falling clock edge; rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drain(input int n);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", 32'(u_dut.state_reg), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0x55 with consumer ready: latency and one-cycle valid
        out_ready = 1'b1;
        popped.delete();
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(negedge rx);
                lat = 0;
                do begin
                    @(posedge clk); #1;
                    lat++;
                end while (!out_valid && lat < 300);
                check("lat_55", lat, 155);
                check("data_55", out_data, 8'h55);
                @(posedge clk); #1;
                check("valid_1cyc", out_valid, 0);
            end
        join
        repeat (20) @(negedge clk);
        check("pops_55", popped.size(), 1);
        check("ferr_55", fe_cnt, 0);

        // Three back-to-back bytes held, then drained in order
        out_ready = 1'b0;
        popped.delete();
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
        repeat (10) @(negedge clk);
        check("cnt3", 32'(u_dut.u_fifo.count_reg), 3);
        check("head_41", out_data, 8'h41);
        repeat (5) @(negedge clk);
        check("stall_41", out_data, 8'h41);
        drain(3);
        repeat (2) @(negedge clk);
        check("drain_n", popped.size(), 3);
        check("drain_0", pq(0), 8'h41);
        check("drain_1", pq(1), 8'h42);
        check("drain_2", pq(2), 8'h43);
        check("drain_empty", out_valid, 0);

        // Five bytes into a depth-4 FIFO: fifth dropped, sticky overflow
        popped.delete();
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 1'b1);
        repeat (10) @(negedge clk);
        check("ovf_set", overflow, 1);
        check("ovf_cnt", 32'(u_dut.u_fifo.count_reg), 4);
        drain(4);
        repeat (2) @(negedge clk);
        check("ovf_n", popped.size(), 4);
        check("ovf_0", pq(0), 8'h01);
        check("ovf_3", pq(3), 8'h04);
        check("ovf_sticky", overflow, 1);
        @(posedge clk); #1;
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // Full FIFO with a pop on the fifth push cycle: nothing dropped
        popped.delete();
        for (int i = 1; i <= 4; i++)
            send_frame(8'h10 + 8'(i), 1'b1);
        fork
            send_frame(8'h15, 1'b1);
            begin
                @(negedge rx);
                repeat (154) @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("pp_ovf", overflow, 0);
        check("pp_cnt", 32'(u_dut.u_fifo.count_reg), 4);
        drain(4);
        repeat (2) @(negedge clk);
        check("pp_n", popped.size(), 5);
        check("pp_0", pq(0), 8'h11);
        check("pp_1", pq(1), 8'h12);
        check("pp_4", pq(4), 8'h15);

        // Bad stop bit then a 40-bit break: one frame_err, no byte
        out_ready = 1'b1;
        popped.delete();
        fe_base = fe_cnt;
        send_frame(8'hA5, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("brk_ferr", fe_cnt - fe_base, 1);
        check("brk_nopush", popped.size(), 0);
        check("brk_state", 32'(u_dut.state_reg), 32'(IDLE));
        send_frame(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        check("after_brk_n", popped.size(), 1);
        check("after_brk_3c", pq(0), 8'h3C);
        check("after_brk_ferr", fe_cnt - fe_base, 1);

        // 5-cycle glitch on an idle line
        popped.delete();
        fe_base = fe_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_push", popped.size(), 0);
        check("glitch_ferr", fe_cnt - fe_base, 0);
        check("glitch_state", 32'(u_dut.state_reg), 32'(IDLE));

        // Reset in the middle of a 0xFF frame while a byte sits in the FIFO
        out_ready = 1'b0;
        popped.delete();
        fe_base = fe_cnt;
        send_frame(8'h77, 1'b1);
        repeat (5) @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_data", out_data, 8'h77);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(negedge rx);
                repeat (60) @(posedge clk);
                #1;
                reset = 1'b1;
                #1;
                check("mid_rst_valid", out_valid, 0);
                check("mid_rst_data", out_data, 0);
                check("mid_rst_state", 32'(u_dut.state_reg), 32'(IDLE));
                repeat (3) @(posedge clk);
                #1;
                reset = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        out_ready = 1'b1;
        send_frame(8'h12, 1'b1);
        repeat (10) @(negedge clk);
        check("post_rst_n", popped.size(), 1);
        check("post_rst_12", pq(0), 8'h12);
        check("post_rst_ferr", fe_cnt - fe_base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
